// File: rtl/score_hud_decoder_pkg.sv
// -----------------------------------------------------------------------------
// hud_pkg
// Shared types and constants for the score HUD decoder.
//   screen_e      : game screen encoding driven by the game controller
//   bcd_t         : one BCD digit
//   dec_state_e   : binary-to-BCD conversion FSM states
//   BCD_DIGITS    : number of BCD digits produced for the score
// -----------------------------------------------------------------------------
package hud_pkg;

    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_PLAY  = 2'd1,
        SCR_OVER  = 2'd2,
        SCR_WIN   = 2'd3
    } screen_e;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_PUBLISH = 2'd2
    } dec_state_e;

    localparam int BCD_DIGITS = 4;

endpackage

// File: rtl/score_hud_decoder_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational correction step of the shift-add-3 (double dabble) engine:
// a BCD nibble of 5 or more gets 3 added so that the following left shift
// carries correctly into the next decimal digit.
//   din_i  : BCD nibble before correction
//   dout_o : corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3
    import hud_pkg::*;
(
    input  bcd_t din_i,
    output bcd_t dout_o
);

    always_comb begin
        dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;
    end

endmodule

// File: rtl/score_hud_decoder.sv
// -----------------------------------------------------------------------------
// score_hud_decoder
// Consumer of the game controller status interface. Converts the binary
// score to four BCD digits (sequential shift-add-3, at most once per frame
// and only when the score changed), registers level / bird-count display
// digits and produces the level-up blink envelope for the HUD drawers.
//
// Ports:
//   clk, resetN        : clock, asynchronous active-low reset
//   startOfFrame       : one-cycle pulse per video frame
//   score              : binary score (SCORE_W bits)
//   level              : zero-based level
//   birdsLeft          : remaining birds (0..10)
//   currScreen         : 0=START 1=PLAY 2=OVER 3=WIN
//   newLevelPulse      : one-cycle level-up pulse
//   scoreDigits        : BCD score, [15:12] thousands .. [3:0] ones
//   digitsUpdated      : one-cycle pulse when scoreDigits is refreshed
//   levelDigit         : level + 1
//   birdsTens/Ones     : decimal digits of birdsLeft
//   hudEnable          : high while on the PLAY screen
//   hudBlink           : blink phase, high = suppress HUD
//   digitBlank         : leading-zero blank mask
//
// Optional feature: define LEADING_ZERO_BLANK_EN to generate digitBlank;
// otherwise digitBlank is tied to zero.
// -----------------------------------------------------------------------------
module score_hud_decoder
    import hud_pkg::*;
#(
    parameter int SCORE_W      = 13,
    parameter int FLASH_FRAMES = 60,
    parameter int BLINK_BIT    = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [SCORE_W-1:0] score,
    input  logic [3:0]         level,
    input  logic [3:0]         birdsLeft,
    input  logic [1:0]         currScreen,
    input  logic               newLevelPulse,
    output logic [15:0]        scoreDigits,
    output logic               digitsUpdated,
    output logic [3:0]         levelDigit,
    output logic [3:0]         birdsTens,
    output logic [3:0]         birdsOnes,
    output logic               hudEnable,
    output logic               hudBlink,
    output logic [3:0]         digitBlank
);

    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int CNT_W = $clog2(SCORE_W);

    // ------------------------------------------------------------------
    // Conversion engine state
    // ------------------------------------------------------------------
    dec_state_e         state_q;
    logic [SCORE_W-1:0] shift_q;
    logic [SCORE_W-1:0] lastScore_q;
    logic               forceConv_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   bitCnt_q;
    logic [BCD_W-1:0]   scoreDigits_q;
    logic               digitsUpdated_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_d;

    for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .din_i  (bcd_q[4*k +: 4]),
            .dout_o (bcd_adj[4*k +: 4])
        );
    end

    // Corrected accumulator shifted left, pulling in the next score bit (MSB first).
    assign bcd_d = {bcd_adj[BCD_W-2:0], shift_q[SCORE_W-1]};

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] digitBlank_q;

    // A digit is blank when it and every higher digit are zero; the ones
    // digit always shows so a score of 0 still renders "0".
    function automatic logic [3:0] blank_mask(input logic [BCD_W-1:0] d);
        logic [3:0] m;
        m[3] = (d[15:12] == 4'd0);
        m[2] = m[3] && (d[11:8] == 4'd0);
        m[1] = m[2] && (d[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= ST_IDLE;
            shift_q         <= '0;
            lastScore_q     <= '0;
            forceConv_q     <= 1'b1;
            bcd_q           <= '0;
            bitCnt_q        <= '0;
            scoreDigits_q   <= '0;
            digitsUpdated_q <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            digitBlank_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    digitsUpdated_q <= 1'b0;
                    if (startOfFrame && ((score != lastScore_q) || forceConv_q)) begin
                        shift_q     <= score;
                        lastScore_q <= score;
                        forceConv_q <= 1'b0;
                        bcd_q       <= '0;
                        bitCnt_q    <= CNT_W'(SCORE_W - 1);
                        state_q     <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q    <= bcd_d;
                    shift_q  <= {shift_q[SCORE_W-2:0], 1'b0};
                    bitCnt_q <= bitCnt_q - 1'b1;
                    // Results are loaded on the last shift so they are already
                    // visible during the PUBLISH cycle.
                    if (bitCnt_q == '0) begin
                        state_q         <= ST_PUBLISH;
                        scoreDigits_q   <= bcd_d;
                        digitsUpdated_q <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                        digitBlank_q    <= blank_mask(bcd_d);
`endif
                    end
                end
                ST_PUBLISH: begin
                    digitsUpdated_q <= 1'b0;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    digitsUpdated_q <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    assign scoreDigits   = scoreDigits_q;
    assign digitsUpdated = digitsUpdated_q;
`ifdef LEADING_ZERO_BLANK_EN
    assign digitBlank    = digitBlank_q;
`else
    assign digitBlank    = 4'b0000;
`endif

    // ------------------------------------------------------------------
    // Side outputs and level-up flash envelope
    // ------------------------------------------------------------------
    logic [3:0] levelDigit_q, birdsTens_q, birdsOnes_q;
    logic       hudEnable_q, hudBlink_q;
    logic [7:0] flashCnt_q, flashCnt_d;
    logic [3:0] birdsTens_d, birdsOnes_d;

    always_comb begin
        birdsTens_d = (birdsLeft >= 4'd10) ? 4'd1 : 4'd0;
        birdsOnes_d = (birdsLeft >= 4'd10) ? birdsLeft - 4'd10 : birdsLeft;
    end

    // A level-up reload takes priority over the per-frame countdown.
    always_comb begin
        flashCnt_d = flashCnt_q;
        if (newLevelPulse) begin
            flashCnt_d = 8'(FLASH_FRAMES);
        end else if (startOfFrame && (flashCnt_q != 8'd0)) begin
            flashCnt_d = flashCnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            levelDigit_q <= '0;
            birdsTens_q  <= '0;
            birdsOnes_q  <= '0;
            hudEnable_q  <= 1'b0;
            hudBlink_q   <= 1'b0;
            flashCnt_q   <= '0;
        end else begin
            levelDigit_q <= level + 4'd1;
            birdsTens_q  <= birdsTens_d;
            birdsOnes_q  <= birdsOnes_d;
            hudEnable_q  <= (currScreen == SCR_PLAY);
            hudBlink_q   <= (flashCnt_q != 8'd0) && flashCnt_q[BLINK_BIT];
            flashCnt_q   <= flashCnt_d;
        end
    end

    assign levelDigit = levelDigit_q;
    assign birdsTens  = birdsTens_q;
    assign birdsOnes  = birdsOnes_q;
    assign hudEnable  = hudEnable_q;
    assign hudBlink   = hudBlink_q;

endmodule

// File: tb/tb_score_hud_decoder.sv
// -----------------------------------------------------------------------------
// tb_score_hud_decoder
// Directed bench for score_hud_decoder with a scoreboard of expected BCD
// results. Define LEADING_ZERO_BLANK_EN to also expect the blank mask.
// -----------------------------------------------------------------------------
module tb_score_hud_decoder;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [12:0] score;
    logic [3:0]  level;
    logic [3:0]  birdsLeft;
    logic [1:0]  currScreen;
    logic        newLevelPulse;
    logic [15:0] scoreDigits;
    logic        digitsUpdated;
    logic [3:0]  levelDigit, birdsTens, birdsOnes, digitBlank;
    logic        hudEnable, hudBlink;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [12:0] tb_last;
    bit          tb_force;
    int          flash_model;

    score_hud_decoder dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .score         (score),
        .level         (level),
        .birdsLeft     (birdsLeft),
        .currScreen    (currScreen),
        .newLevelPulse (newLevelPulse),
        .scoreDigits   (scoreDigits),
        .digitsUpdated (digitsUpdated),
        .levelDigit    (levelDigit),
        .birdsTens     (birdsTens),
        .birdsOnes     (birdsOnes),
        .hudEnable     (hudEnable),
        .hudBlink      (hudBlink),
        .digitBlank    (digitBlank)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [3:0] exp_blank(input int v);
`ifdef LEADING_ZERO_BLANK_EN
        logic [3:0] m;
        m[3] = (v < 1000);
        m[2] = (v < 100);
        m[1] = (v < 10);
        m[0] = 1'b0;
        return m;
`else
        return (v >= 0) ? 4'b0000 : 4'b0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse startOfFrame for one cycle from IDLE; record the expected result
    // when the score differs from the last converted one (or after reset).
    task automatic frame_start();
        @(negedge clk);
        startOfFrame = 1'b1;
        if ((score != tb_last) || tb_force) begin
            exp_q.push_back(to_bcd(int'(score)));
            tb_last  = score;
            tb_force = 1'b0;
        end
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
    endtask

    // Wait (bounded) for digitsUpdated after a frame_start. Optionally change
    // the score and pulse startOfFrame at cycle change_at while converting.
    task automatic wait_result(input string tag, input int change_at, input logic [12:0] new_score);
        int cyc;
        int lat;
        logic [15:0] e;
        cyc = 0;
        lat = 0;
        while (cyc < 24 && lat == 0) begin
            @(posedge clk);
            #1;
            cyc++;
            startOfFrame = 1'b0;
            if (cyc == change_at) begin
                score        = new_score;
                startOfFrame = 1'b1;
            end
            if (digitsUpdated) lat = cyc;
        end
        startOfFrame = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, "_no_update"}, 32'(lat), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'd13);
            chk({tag, "_digits"}, 32'(scoreDigits), 32'(e));
            chk({tag, "_blank"}, 32'(digitBlank),
                32'(exp_blank(int'(e[15:12]) * 1000 + int'(e[11:8]) * 100 + int'(e[7:4]) * 10 + int'(e[3:0]))));
            @(posedge clk);
            #1;
            chk({tag, "_pulse_end"}, 32'(digitsUpdated), 32'd0);
        end
    endtask

    // One frame for the flash test; blink is checked once its register has
    // followed the counter.
    task automatic flash_frame(input string tag, input bit with_pulse);
        @(negedge clk);
        startOfFrame  = 1'b1;
        newLevelPulse = with_pulse;
        if (with_pulse) flash_model = 60;
        else if (flash_model != 0) flash_model--;
        @(posedge clk);
        #1;
        startOfFrame  = 1'b0;
        newLevelPulse = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, 32'(hudBlink), 32'((flash_model != 0) && ((flash_model >> 2) & 1)));
    endtask

    initial begin
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        score         = '0;
        level         = '0;
        birdsLeft     = '0;
        currScreen    = 2'd0;
        newLevelPulse = 1'b0;
        tb_last       = '0;
        tb_force      = 1'b1;
        flash_model   = 0;

        #2;
        chk("rst_digits", 32'(scoreDigits), 32'd0);
        chk("rst_updated", 32'(digitsUpdated), 32'd0);
        chk("rst_level", 32'(levelDigit), 32'd0);
        chk("rst_hud", 32'({hudEnable, hudBlink, birdsTens, birdsOnes, digitBlank}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;

        // Forced first conversion of score 0
        frame_start();
        wait_result("force0", -1, '0);

        // 1234, then unchanged frame
        score = 13'd1234;
        frame_start();
        wait_result("s1234", -1, '0);
        frame_start();
        wait_result("s1234_same", -1, '0);

        // Full-scale value, then change + stray frame pulse mid-conversion
        score = 13'd8191;
        frame_start();
        wait_result("s8191", 5, 13'd8190);
        frame_start();
        wait_result("s8190", -1, '0);

        // Side outputs
        @(negedge clk);
        level = 4'd4; birdsLeft = 4'd10; currScreen = 2'd1;
        @(posedge clk); #1;
        chk("levelDigit", 32'(levelDigit), 32'd5);
        chk("birds10_tens", 32'(birdsTens), 32'd1);
        chk("birds10_ones", 32'(birdsOnes), 32'd0);
        chk("hudEnable_play", 32'(hudEnable), 32'd1);
        @(negedge clk);
        birdsLeft = 4'd7; currScreen = 2'd2;
        @(posedge clk); #1;
        chk("birds7_tens", 32'(birdsTens), 32'd0);
        chk("birds7_ones", 32'(birdsOnes), 32'd7);
        chk("hudEnable_over", 32'(hudEnable), 32'd0);

        // Level-up flash envelope (score unchanged, so no conversions)
        @(negedge clk);
        newLevelPulse = 1'b1;
        flash_model = 60;
        @(posedge clk); #1;
        newLevelPulse = 1'b0;
        @(posedge clk); #1;
        chk("blink_load", 32'(hudBlink), 32'd1);
        for (int i = 1; i <= 61; i++) begin
            flash_frame($sformatf("blink_f%0d", i), 1'b0);
        end
        flash_frame("blink_coincident", 1'b1);
        flash_frame("blink_after_coincident", 1'b0);

        // Leading-zero blanking
        score = 13'd42;
        frame_start();
        wait_result("s42", -1, '0);
        score = 13'd0;
        frame_start();
        wait_result("s0", -1, '0);

        // Reset asserted mid-conversion
        score = 13'd5555;
        frame_start();
        repeat (4) @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        chk("midrst_digits", 32'(scoreDigits), 32'd0);
        chk("midrst_updated", 32'(digitsUpdated), 32'd0);
        chk("midrst_side", 32'({levelDigit, birdsTens, birdsOnes, hudEnable, hudBlink, digitBlank}), 32'd0);
        exp_q.delete();
        tb_force = 1'b1;
        tb_last  = '0;
        @(negedge clk);
        resetN = 1'b1;
        frame_start();
        wait_result("post_rst", -1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
